// File: rtl/cpu_fifo_bridge.sv
// CPU-side endpoint of the CPU<->FPGA FIFO link: serializes one blocking request
// into tagged FIFO words and reassembles the two-word read response.
module cpu_fifo_bridge #(
  parameter int ADDRESS_DATA_WIDTH = 34
) (
  input  logic                          cpu_clk,
  input  logic                          rst,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic [31:0]                   mem_addr,
  input  logic [63:0]                   mem_wdata,
  output logic [63:0]                   mem_rdata,
  output logic                          mem_resp,
  output logic                          w_en_CPU_to_FPGA_FIFO,
  output logic [ADDRESS_DATA_WIDTH-1:0] wdata_CPU_to_FPGA_FIFO,
  input  logic                          full_CPU_to_FPGA_FIFO,
  output logic                          r_en_FPGA_to_CPU_FIFO,
  input  logic [ADDRESS_DATA_WIDTH-1:0] rdata_FPGA_to_CPU_FIFO,
  input  logic                          empty_FPGA_to_CPU_FIFO,
  output logic                          error
);

  localparam int PW = ADDRESS_DATA_WIDTH - 2;

  localparam logic [1:0] TAG_RADDR = 2'b00;
  localparam logic [1:0] TAG_WADDR = 2'b01;
  localparam logic [1:0] TAG_DLO   = 2'b10;
  localparam logic [1:0] TAG_DHI   = 2'b11;

  typedef enum logic [3:0] {
    IDLE, SEND_ADDR, SEND_DLO, SEND_DHI, POP_DLO, CAP_DLO, POP_DHI, CAP_DHI, RESP
  } state_t;

  typedef struct packed {
    logic        is_read;
    logic [63:0] data;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q;
  logic   push, pop;
  logic [1:0] rtag;

  assign push = w_en_CPU_to_FPGA_FIFO;
  assign pop  = r_en_FPGA_to_CPU_FIFO;
  assign rtag = rdata_FPGA_to_CPU_FIFO[ADDRESS_DATA_WIDTH-1 -: 2];

  always_ff @(posedge cpu_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (mem_read || mem_write) state_nxt = SEND_ADDR;
      SEND_ADDR: if (push) state_nxt = req_q.is_read ? POP_DLO : SEND_DLO;
      SEND_DLO:  if (push) state_nxt = SEND_DHI;
      SEND_DHI:  if (push) state_nxt = RESP;
      POP_DLO:   if (pop)  state_nxt = CAP_DLO;
      CAP_DLO:   state_nxt = POP_DHI;
      POP_DHI:   if (pop)  state_nxt = CAP_DHI;
      CAP_DHI:   state_nxt = RESP;
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_en_CPU_to_FPGA_FIFO = 1'b0;
    r_en_FPGA_to_CPU_FIFO = 1'b0;
    case (state)
      SEND_ADDR, SEND_DLO, SEND_DHI: w_en_CPU_to_FPGA_FIFO = !full_CPU_to_FPGA_FIFO;
      POP_DLO, POP_DHI:              r_en_FPGA_to_CPU_FIFO = !empty_FPGA_to_CPU_FIFO;
      default: ;
    endcase
  end

  // The outgoing word register is preloaded with the next word on each push,
  // so it stays stable while the FIFO is full.
  always_ff @(posedge cpu_clk or negedge rst) begin
    if (!rst) begin
      req_q                  <= '0;
      wdata_CPU_to_FPGA_FIFO <= '0;
      mem_rdata              <= '0;
      mem_resp               <= 1'b0;
      error                  <= 1'b0;
    end else begin
      mem_resp <= (state_nxt == RESP);
      case (state)
        IDLE: begin
          if (mem_read) begin
            req_q.is_read          <= 1'b1;
            wdata_CPU_to_FPGA_FIFO <= {TAG_RADDR, mem_addr};
          end else if (mem_write) begin
            req_q.is_read          <= 1'b0;
            req_q.data             <= mem_wdata;
            wdata_CPU_to_FPGA_FIFO <= {TAG_WADDR, mem_addr};
          end
        end
        SEND_ADDR: if (push && !req_q.is_read)
          wdata_CPU_to_FPGA_FIFO <= {TAG_DLO, req_q.data[31:0]};
        SEND_DLO: if (push)
          wdata_CPU_to_FPGA_FIFO <= {TAG_DHI, req_q.data[63:32]};
        CAP_DLO: begin
          mem_rdata[31:0] <= rdata_FPGA_to_CPU_FIFO[PW-1:0];
          if (rtag != TAG_DLO) error <= 1'b1;
        end
        CAP_DHI: begin
          mem_rdata[63:32] <= rdata_FPGA_to_CPU_FIFO[PW-1:0];
          if (rtag != TAG_DHI) error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_fifo_bridge.sv
// Directed bench for cpu_fifo_bridge: scoreboarded FIFO words, cycle-accurate
// push/pop masks and read-data checks around a small FIFO model.
module tb_cpu_fifo_bridge;

  logic        cpu_clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_resp;
  logic        w_en;
  logic [33:0] wdata;
  logic        full;
  logic        r_en;
  logic [33:0] rdata_f2c;
  logic        empty;
  logic        error;

  int n_assert = 0;
  int n_fail   = 0;

  logic [33:0] exp_q[$];
  logic [33:0] resp_q[$];

  int          lat, err_first;
  logic [63:0] wm, rm;

  cpu_fifo_bridge #(.ADDRESS_DATA_WIDTH(34)) dut (
    .cpu_clk(cpu_clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .w_en_CPU_to_FPGA_FIFO(w_en), .wdata_CPU_to_FPGA_FIFO(wdata), .full_CPU_to_FPGA_FIFO(full),
    .r_en_FPGA_to_CPU_FIFO(r_en), .rdata_FPGA_to_CPU_FIFO(rdata_f2c), .empty_FPGA_to_CPU_FIFO(empty),
    .error(error)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request; k counts cycles after the IDLE sampling cycle (cycle 0).
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [63:0] fm, input logic [63:0] em,
                         output int lt, output logic [63:0] wmask, output logic [63:0] rmask,
                         output int ef);
    bit pop_prev;
    pop_prev = 0; lt = -1; wmask = '0; rmask = '0; ef = -1;
    @(negedge cpu_clk);
    mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wd;
    full = 1'b0; empty = (resp_q.size() == 0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge cpu_clk);
      if (pop_prev) rdata_f2c = resp_q.pop_front();
      full  = fm[k];
      empty = (resp_q.size() == 0) || em[k];
      #1;
      if (w_en) begin
        wmask[k] = 1'b1;
        if (exp_q.size() == 0) begin
          n_assert++; n_fail++;
          $error("FAIL unexpected_push: observed %0h expected no push", wdata);
        end else chk("push_word", {30'd0, wdata}, {30'd0, exp_q.pop_front()});
      end
      if (full && exp_q.size() != 0) chk("hold_word", {30'd0, wdata}, {30'd0, exp_q[0]});
      if (r_en) rmask[k] = 1'b1;
      chk("push_when_full", w_en & full, 0);
      chk("pop_when_empty", r_en & empty, 0);
      chk("wen_and_ren", w_en & r_en, 0);
      if (error && ef < 0) ef = k;
      pop_prev = r_en && !empty;
      if (mem_resp) begin lt = k; break; end
    end
    mem_read = 1'b0; mem_write = 1'b0; full = 1'b0;
    if (lt < 0) begin
      n_assert++; n_fail++;
      $error("FAIL resp_timeout: observed no mem_resp expected within 40 cycles");
    end
    chk("words_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b0; mem_read = 0; mem_write = 0; mem_addr = '0; mem_wdata = '0;
    full = 1'b0; empty = 1'b1; rdata_f2c = '0;
    #1;
    chk("rst_w_en", w_en, 0);      chk("rst_wdata", wdata, 0);
    chk("rst_r_en", r_en, 0);      chk("rst_mem_resp", mem_resp, 0);
    chk("rst_mem_rdata", mem_rdata, 0); chk("rst_error", error, 0);
    @(negedge cpu_clk); @(negedge cpu_clk);
    rst = 1'b1;

    // basic write
    exp_q.push_back(34'h1_0000_1000); exp_q.push_back(34'h2_0123_4567); exp_q.push_back(34'h3_DEAD_BEEF);
    run_txn(0, 1, 32'h0000_1000, 64'hDEAD_BEEF_0123_4567, '0, '0, lat, wm, rm, err_first);
    chk("wr_lat", lat, 4); chk("wr_wmask", wm, 64'h0E); chk("wr_rmask", rm, 0);

    // basic read
    exp_q.push_back(34'h0_0000_0020);
    resp_q.push_back(34'h2_AAAA_5555); resp_q.push_back(34'h3_1234_5678);
    run_txn(1, 0, 32'h20, '0, '0, '0, lat, wm, rm, err_first);
    chk("rd_lat", lat, 6); chk("rd_wmask", wm, 64'h02); chk("rd_rmask", rm, 64'h14);
    chk("rd_data", mem_rdata, 64'h1234_5678_AAAA_5555); chk("rd_error", error, 0);

    // write with full during SEND_DLO for 3 cycles
    exp_q.push_back(34'h1_4000_0008); exp_q.push_back(34'h2_3333_4444); exp_q.push_back(34'h3_1111_2222);
    run_txn(0, 1, 32'h4000_0008, 64'h1111_2222_3333_4444, 64'h1C, '0, lat, wm, rm, err_first);
    chk("full_lat", lat, 7); chk("full_wmask", wm, 64'h62);
    chk("rdata_hold", mem_rdata, 64'h1234_5678_AAAA_5555);

    // read with one empty cycle in POP_DLO
    exp_q.push_back(34'h0_0000_0ABC);
    resp_q.push_back(34'h2_CAFE_F00D); resp_q.push_back(34'h3_0BAD_C0DE);
    run_txn(1, 0, 32'h0ABC, '0, '0, 64'h04, lat, wm, rm, err_first);
    chk("empty_lat", lat, 7); chk("empty_rmask", rm, 64'h28); chk("empty_wmask", wm, 64'h02);
    chk("empty_data", mem_rdata, 64'h0BAD_C0DE_CAFE_F00D);

    // read and write together: read wins
    exp_q.push_back(34'h0_0000_0100);
    resp_q.push_back(34'h2_0000_0001); resp_q.push_back(34'h3_0000_0002);
    run_txn(1, 1, 32'h0100, 64'hFFFF_FFFF_FFFF_FFFF, '0, '0, lat, wm, rm, err_first);
    chk("both_lat", lat, 6); chk("both_wmask", wm, 64'h02);
    chk("both_data", mem_rdata, 64'h0000_0002_0000_0001); chk("both_error", error, 0);

    // swapped tags
    exp_q.push_back(34'h0_0000_0030);
    resp_q.push_back(34'h3_5555_6666); resp_q.push_back(34'h2_7777_8888);
    run_txn(1, 0, 32'h30, '0, '0, '0, lat, wm, rm, err_first);
    chk("swap_lat", lat, 6); chk("swap_err_first", err_first, 4);
    chk("swap_data", mem_rdata, 64'h7777_8888_5555_6666); chk("swap_error", error, 1);

    // clean read after error: error stays set
    exp_q.push_back(34'h0_0000_0040);
    resp_q.push_back(34'h2_0000_0010); resp_q.push_back(34'h3_0000_0020);
    run_txn(1, 0, 32'h40, '0, '0, '0, lat, wm, rm, err_first);
    chk("sticky_lat", lat, 6); chk("sticky_data", mem_rdata, 64'h0000_0020_0000_0010);
    chk("sticky_error", error, 1);

    // reset during SEND_DLO
    @(negedge cpu_clk);
    mem_write = 1'b1; mem_addr = 32'h50; mem_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge cpu_clk); #1;
    chk("mid_addr_wen", w_en, 1); chk("mid_addr_word", wdata, 34'h1_0000_0050);
    @(negedge cpu_clk); #1;
    chk("mid_dlo_wen", w_en, 1); chk("mid_dlo_word", wdata, 34'h2_CCCC_DDDD);
    rst = 1'b0; mem_write = 1'b0;
    #1;
    chk("mid_rst_w_en", w_en, 0);      chk("mid_rst_wdata", wdata, 0);
    chk("mid_rst_r_en", r_en, 0);      chk("mid_rst_mem_resp", mem_resp, 0);
    chk("mid_rst_mem_rdata", mem_rdata, 0); chk("mid_rst_error", error, 0);
    @(negedge cpu_clk);
    rst = 1'b1;

    // write after reset
    exp_q.push_back(34'h1_0000_0060); exp_q.push_back(34'h2_0506_0708); exp_q.push_back(34'h3_0102_0304);
    run_txn(0, 1, 32'h60, 64'h0102_0304_0506_0708, '0, '0, lat, wm, rm, err_first);
    chk("post_lat", lat, 4); chk("post_wmask", wm, 64'h0E); chk("post_error", error, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
